ic_slice_udiv_witness: RTL and testbench
========================================

IC_SLICE_UDIV_WITNESS -- requirements
Module: ic_slice_udiv_witness

Interface
REQ-001 Parameter W, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 in_valid  in  1  request valid.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 mode  in  2  predicate P: 00 = bvsle, 01 = bvsge, 10 = bvule, 11 = bvuge.
REQ-007 s  in  W  divisor operand.
REQ-008 t  in  W  bound operand.
REQ-009 out_valid  out  1  result valid.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 ic  out  1  invertibility condition: some x exists with P(x udiv s, t).
REQ-012 x  out  W  Skolem witness.
REQ-013 q  out  W  x udiv s, computed by the block.

Function
REQ-014 Accept a request only on a rising edge with in_valid=1 and in_ready=1; capture mode, s and t on that edge.
REQ-015 Division semantics are SMT-LIB: x udiv 0 = all-ones, and x urem 0 = x.
REQ-016 Witness x is chosen combinationally from the captured operands:
- sle: x = t when s=1; otherwise x = 0.
- sge: x = t when s=1; x = 0 when s=0; otherwise x = all-ones.
- ule: x = 0.
- uge: x = all-ones.
REQ-017 A serial restoring divider computes q = x udiv s at one quotient bit per cycle, MSB first, taking exactly W cycles for every divisor, including s=0.
REQ-018 ic = P(q, t): signed compare for sle/sge, unsigned compare for ule/uge.
REQ-019 FSM states are IDLE, DIV and DONE.
- IDLE -> DIV on accept.
- DIV -> DONE after W cycles.
- DONE -> IDLE on out_valid & out_ready.
REQ-020 in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-021 out_valid rises exactly W+1 rising edges after the accepting edge.
REQ-022 While out_valid=1 and out_ready=0, ic, x and q stay stable.
REQ-023 A new request is accepted no earlier than the edge after the output handshake, so at most one transaction is in flight.
REQ-024 in_valid is ignored outside IDLE; operand changes during DIV or DONE do not affect the result.
REQ-025 The divider's internal remainder is W+1 bits wide; no carry is lost at W=32.

Reset
REQ-026 When rst=1 at a rising edge, the next state is IDLE, out_valid=0, in_ready=1, and ic, x and q are all 0.
REQ-027 Reset asserted during DIV or DONE aborts the transaction; the result is never presented.
REQ-028 rst overrides a simultaneous in_valid or out_ready handshake.

Structure
REQ-029 Shared package ic_pkg holds:
- the mode enum (IC_SLE, IC_SGE, IC_ULE, IC_UGE);
- the state enum (ST_IDLE, ST_DIV, ST_DONE);
- W range-check constants.
REQ-030 The divider is sub-module serial_udiv, parameterised by W, with ports start, dividend, divisor, busy, done, quot and rem.
REQ-031 The witness select and predicate compare remain in the top level, which has no further sub-modules.

Verification (W=4)
REQ-032 Request mode=sle, s=0, t=0xE -> response x=0, q=0xF, ic=0, out_valid exactly 5 edges after accept.
REQ-033 Two requests:
- mode=uge, s=3, t=6 -> x=0xF, q=5, ic=0;
- mode=uge, s=3, t=5 -> ic=1.
REQ-034 Request mode=sge, s=1, t=0x9 -> x=9, q=9, ic=1.
REQ-035 Request mode=ule, s=0, t=0xF -> x=0, q=0xF, ic=1.
REQ-036 Hold out_ready=0 for 3 cycles in DONE -> outputs stay stable and in_ready=0; when out_ready=1, in_ready=1 on the next cycle.
REQ-037 Assert rst at the 2nd DIV cycle -> next cycle is IDLE with out_valid=0 and in_ready=1; no result appears.
REQ-038 Randomised self-check over all 2^(4+4+2) input combinations: ic matches an exhaustive search over every x.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared types and limits for the unsigned-division invertibility-condition slice.
package ic_pkg;

   localparam int W_MIN = 2;
   localparam int W_MAX = 32;

   typedef enum logic [1:0] {
      IC_SLE = 2'b00,
      IC_SGE = 2'b01,
      IC_ULE = 2'b10,
      IC_UGE = 2'b11
   } ic_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DIV  = 2'b01,
      ST_DONE = 2'b10
   } ic_state_e;

endpackage

// File: rtl/serial_udiv.sv
// Restoring divider producing one quotient bit per cycle, MSB first, W cycles per divide.
// A zero divisor naturally yields an all-ones quotient and remainder equal to the dividend.
module serial_udiv
   import ic_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quot,
   output logic [W:0]   rem
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  dvd_r;
   logic [W-1:0]  dsr_r;
   logic [W-1:0]  quot_r;
   logic [W:0]    rem_r;
   logic [CW-1:0] cnt_r;
   logic          busy_r;
   logic          done_r;

   logic [W-1:0]  step_dvd_s;
   logic [W-1:0]  step_dsr_s;
   logic [W-1:0]  step_quot_s;
   logic [W:0]    step_rem_s;
   logic [W:0]    shift_s;
   logic [W:0]    diff_s;
   logic          ge_s;

   // One restoring step; the start cycle already consumes the first dividend bit.
   always_comb begin
      if (start) begin
         step_dvd_s  = dividend;
         step_dsr_s  = divisor;
         step_quot_s = {W{1'b0}};
         step_rem_s  = {(W+1){1'b0}};
      end else begin
         step_dvd_s  = dvd_r;
         step_dsr_s  = dsr_r;
         step_quot_s = quot_r;
         step_rem_s  = rem_r;
      end
      shift_s = {step_rem_s[W-1:0], step_dvd_s[W-1]};
      diff_s  = shift_s - {1'b0, step_dsr_s};
      ge_s    = (shift_s >= {1'b0, step_dsr_s});
   end

   // Iteration state and completion pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_r  <= {W{1'b0}};
         dsr_r  <= {W{1'b0}};
         quot_r <= {W{1'b0}};
         rem_r  <= {(W+1){1'b0}};
         cnt_r  <= {CW{1'b0}};
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (start || busy_r) begin
         dvd_r  <= {step_dvd_s[W-2:0], 1'b0};
         dsr_r  <= step_dsr_s;
         quot_r <= {step_quot_s[W-2:0], ge_s};
         rem_r  <= ge_s ? diff_s : shift_s;
         if (start) begin
            cnt_r  <= CW'(W - 1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
         end else if (cnt_r == CW'(1)) begin
            cnt_r  <= cnt_r - CW'(1);
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end else begin
            cnt_r  <= cnt_r - CW'(1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
         end
      end else begin
         done_r <= 1'b0;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign quot = quot_r;
   assign rem  = rem_r;

endmodule

// File: rtl/ic_slice_udiv_witness.sv
// Invertibility condition for P(x udiv s, t): picks a witness x, divides it serially,
// and reports whether the predicate holds for the resulting quotient.
module ic_slice_udiv_witness
   import ic_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   mode,
   input  logic [W-1:0] s,
   input  logic [W-1:0] t,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         ic,
   output logic [W-1:0] x,
   output logic [W-1:0] q
);

   if (W < W_MIN || W > W_MAX) begin : g_bad_width
      $error("ic_slice_udiv_witness: W out of range");
   end

   ic_state_e    state_r;
   ic_mode_e     mode_r;
   logic [W-1:0] s_r;
   logic [W-1:0] t_r;
   logic         start_r;
   logic         in_ready_r;
   logic         out_valid_r;
   logic         ic_r;
   logic [W-1:0] x_r;
   logic [W-1:0] q_r;

   logic [W-1:0] x_s;
   logic         ic_s;
   logic         div_done_s;
   logic [W-1:0] div_quot_s;
   logic         div_busy_unused_s;
   logic [W:0]   div_rem_unused_s;

   // Witness choice: extreme dividends, or t itself when s=1 makes the quotient equal x.
   always_comb begin
      x_s = {W{1'b0}};
      case (mode_r)
         IC_SLE: begin
            if (s_r == W'(1)) x_s = t_r;
            else              x_s = {W{1'b0}};
         end
         IC_SGE: begin
            if (s_r == W'(1))      x_s = t_r;
            else if (s_r == W'(0)) x_s = {W{1'b0}};
            else                   x_s = {W{1'b1}};
         end
         IC_ULE:  x_s = {W{1'b0}};
         IC_UGE:  x_s = {W{1'b1}};
         default: x_s = {W{1'b0}};
      endcase
   end

   // Predicate applied to the divider's quotient.
   always_comb begin
      ic_s = 1'b0;
      case (mode_r)
         IC_SLE:  ic_s = ($signed(div_quot_s) <= $signed(t_r));
         IC_SGE:  ic_s = ($signed(div_quot_s) >= $signed(t_r));
         IC_ULE:  ic_s = (div_quot_s <= t_r);
         IC_UGE:  ic_s = (div_quot_s >= t_r);
         default: ic_s = 1'b0;
      endcase
   end

   serial_udiv #(.W(W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (start_r),
      .dividend (x_s),
      .divisor  (s_r),
      .busy     (div_busy_unused_s),
      .done     (div_done_s),
      .quot     (div_quot_s),
      .rem      (div_rem_unused_s)
   );

   // Control FSM: operands are frozen from accept until the next accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         mode_r      <= IC_SLE;
         s_r         <= {W{1'b0}};
         t_r         <= {W{1'b0}};
         start_r     <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         ic_r        <= 1'b0;
         x_r         <= {W{1'b0}};
         q_r         <= {W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  mode_r     <= ic_mode_e'(mode);
                  s_r        <= s;
                  t_r        <= t;
                  start_r    <= 1'b1;
                  in_ready_r <= 1'b0;
                  state_r    <= ST_DIV;
               end else begin
                  start_r <= 1'b0;
               end
            end
            ST_DIV: begin
               start_r <= 1'b0;
               if (div_done_s) begin
                  ic_r        <= ic_s;
                  x_r         <= x_s;
                  q_r         <= div_quot_s;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               start_r     <= 1'b0;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign ic        = ic_r;
   assign x         = x_r;
   assign q         = q_r;

endmodule

// File: tb/tb_ic_slice_udiv_witness.sv
// Directed and exhaustive checks of ic_slice_udiv_witness at W=4.
module tb_ic_slice_udiv_witness;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   mode;
   logic [W-1:0] s;
   logic [W-1:0] t;
   logic         out_valid;
   logic         out_ready;
   logic         ic;
   logic [W-1:0] x;
   logic [W-1:0] q;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ic_slice_udiv_witness #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .s         (s),
      .t         (t),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ic        (ic),
      .x         (x),
      .q         (q)
   );

   always #5 clk = ~clk;

   task tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one request, scramble operands afterwards, and count edges until out_valid.
   task send(input logic [1:0] m, input logic [W-1:0] sv, input logic [W-1:0] tv, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      mode = m; s = sv; t = tv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      mode = ~m; s = ~sv; t = ~tv;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task finish_xfer;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task test_reset;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      mode = 2'b11; s = 4'h3; t = 4'h1;
      repeat (2) tick();
      total_cnt++;
      if ({out_valid, in_ready, ic, x, q} !== {1'b0, 1'b1, 1'b0, 4'h0, 4'h0})
         $display("FAIL reset_state got ov=%b ir=%b ic=%b x=%h q=%h want ov=0 ir=1 ic=0 x=0 q=0",
                  out_valid, in_ready, ic, x, q);
      else pass_cnt++;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();
   endtask

   task test_sle_div0;
      int lat;
      send(2'b00, 4'h0, 4'hE, lat);
      total_cnt++;
      if (lat !== 5) $display("FAIL sle_div0_latency got %0d want 5", lat);
      else pass_cnt++;
      total_cnt++;
      if ({ic, x, q} !== {1'b0, 4'h0, 4'hF})
         $display("FAIL sle_div0_result got ic=%b x=%h q=%h want ic=0 x=0 q=f", ic, x, q);
      else pass_cnt++;
      finish_xfer();
   endtask

   task test_back_to_back;
      int lat;
      send(2'b11, 4'h3, 4'h6, lat);
      total_cnt++;
      if ({ic, x, q} !== {1'b0, 4'hF, 4'h5})
         $display("FAIL uge_t6_result got ic=%b x=%h q=%h want ic=0 x=f q=5", ic, x, q);
      else pass_cnt++;
      finish_xfer();
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b want 1", in_ready);
      else pass_cnt++;
      send(2'b11, 4'h3, 4'h5, lat);
      total_cnt++;
      if (lat !== 5) $display("FAIL uge_t5_latency got %0d want 5", lat);
      else pass_cnt++;
      total_cnt++;
      if ({ic, x, q} !== {1'b1, 4'hF, 4'h5})
         $display("FAIL uge_t5_result got ic=%b x=%h q=%h want ic=1 x=f q=5", ic, x, q);
      else pass_cnt++;
      finish_xfer();
   endtask

   task test_sge_s1;
      int lat;
      send(2'b01, 4'h1, 4'h9, lat);
      total_cnt++;
      if ({ic, x, q} !== {1'b1, 4'h9, 4'h9})
         $display("FAIL sge_s1_result got ic=%b x=%h q=%h want ic=1 x=9 q=9", ic, x, q);
      else pass_cnt++;
      finish_xfer();
   endtask

   task test_ule_div0;
      int lat;
      send(2'b10, 4'h0, 4'hF, lat);
      total_cnt++;
      if ({ic, x, q} !== {1'b1, 4'h0, 4'hF})
         $display("FAIL ule_div0_result got ic=%b x=%h q=%h want ic=1 x=0 q=f", ic, x, q);
      else pass_cnt++;
      finish_xfer();
   endtask

   // sge, s=2, t=3: x=f, q=7, 7>=3 signed.
   task test_backpressure;
      int lat;
      send(2'b01, 4'h2, 4'h3, lat);
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if ({out_valid, in_ready, ic, x, q} !== {1'b1, 1'b0, 1'b1, 4'hF, 4'h7})
            $display("FAIL hold_cycle%0d got ov=%b ir=%b ic=%b x=%h q=%h want ov=1 ir=0 ic=1 x=f q=7",
                     i, out_valid, in_ready, ic, x, q);
         else pass_cnt++;
         tick();
      end
      finish_xfer();
      total_cnt++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL hold_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
      else pass_cnt++;
   endtask

   task test_reset_mid_div;
      bit seen;
      mode = 2'b11; s = 4'h3; t = 4'h1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total_cnt++;
      if ({out_valid, in_ready, ic, x, q} !== {1'b0, 1'b1, 1'b0, 4'h0, 4'h0})
         $display("FAIL abort_state got ov=%b ir=%b ic=%b x=%h q=%h want ov=0 ir=1 ic=0 x=0 q=0",
                  out_valid, in_ready, ic, x, q);
      else pass_cnt++;
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (10) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      out_ready = 1'b0;
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL abort_no_result got out_valid seen=%b want 0", seen);
      else pass_cnt++;
   endtask

   // All mode/s/t combinations in a shuffled order; ic compared with a search over every x.
   task test_exhaustive;
      int lat, idx, off, hold, mi, sv, tv;
      logic exp_ic;
      logic [W-1:0] qq, tt;
      off = int'($urandom_range(0, 1023));
      for (int k = 0; k < 1024; k++) begin
         idx = (k * 397 + off) % 1024;
         mi = idx / 256; sv = (idx / 16) % 16; tv = idx % 16;
         tt = 4'(tv);
         send(2'(mi), 4'(sv), tt, lat);
         exp_ic = 1'b0;
         for (int xv = 0; xv < 16; xv++) begin
            qq = (sv == 0) ? 4'hF : 4'(xv / sv);
            case (mi)
               0:       if ($signed(qq) <= $signed(tt)) exp_ic = 1'b1;
               1:       if ($signed(qq) >= $signed(tt)) exp_ic = 1'b1;
               2:       if (qq <= tt) exp_ic = 1'b1;
               default: if (qq >= tt) exp_ic = 1'b1;
            endcase
         end
         total_cnt++;
         if (out_valid !== 1'b1 || ic !== exp_ic)
            $display("FAIL exh_ic mode=%0d s=%0d t=%0d got ov=%b ic=%b want ov=1 ic=%b",
                     mi, sv, tv, out_valid, ic, exp_ic);
         else pass_cnt++;
         hold = int'($urandom_range(0, 2));
         repeat (hold) tick();
         finish_xfer();
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      mode = 2'b00; s = 4'h0; t = 4'h0;
      test_reset();
      test_sle_div0();
      test_back_to_back();
      test_sge_s1();
      test_ule_div0();
      test_backpressure();
      test_reset_mid_div();
      test_exhaustive();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
